// File: rtl/bcd_updown_chain.sv
// Multi-digit BCD up/down counter with ripple carry/borrow, parallel load,
// wrap/saturate limits, terminal count and overflow / bad-load pulses.
module bcd_updown_chain #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                up,
  input  logic                sat,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                ovf,
  output logic                bad_load
);

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic [DIGITS:0]        lower_max, lower_min;
  logic [DIGITS-1:0]      nib_bad;
  logic                   at_max, at_min, at_limit, hold_limit;
  logic                   ovf_q, ovf_d, bad_q, bad_d;

  // lower_max[k] / lower_min[k]: every digit below k is 9 / 0
  assign lower_max[0] = 1'b1;
  assign lower_min[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur, ld_val, inc_val, dec_val;
      logic       step;

      assign cur              = cnt_q[gi];
      assign nib_bad[gi]      = din[4*gi +: 4] > 4'd9;
      assign ld_val           = nib_bad[gi] ? 4'd9 : din[4*gi +: 4];
      assign lower_max[gi+1]  = lower_max[gi] & (cur == 4'd9);
      assign lower_min[gi+1]  = lower_min[gi] & (cur == 4'd0);
      assign inc_val          = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      assign dec_val          = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      assign step             = ce & ~hold_limit & (up ? lower_max[gi] : lower_min[gi]);
      assign cnt_d[gi]        = load ? ld_val : (step ? (up ? inc_val : dec_val) : cur);
    end
  endgenerate

  assign at_max     = lower_max[DIGITS];
  assign at_min     = lower_min[DIGITS];
  assign at_limit   = up ? at_max : at_min;
  // Saturation freezes every digit; wrap falls out of the ripple naturally.
  assign hold_limit = sat & at_limit;
  assign tc         = ce & ~load & at_limit;
  assign ovf_d      = tc;
  assign bad_d      = load & (|nib_bad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      bad_q <= bad_d;
    end
  end

  assign q        = cnt_q;
  assign ovf      = ovf_q;
  assign bad_load = bad_q;

endmodule

// File: doc/bcd_updown_chain.md
# bcd_updown_chain

Parametrised multi-digit BCD up/down counter. Digits are chained by a ripple carry/borrow, so the whole word counts as one decimal number. The block adds synchronous parallel load, wrap or saturate behaviour at the range limits, a terminal-count output, and an overflow/underflow pulse. It is the next-generation decimal counter for the display and counting paths: a 7-segment scanner or a higher-level controller consumes `q` directly.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: reset; asynchronous, active-high; clears all state.
- `ce`  in  1: count enable; one decimal step per cycle when high.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `sat`  in  1: limit mode; 0 = wrap, 1 = saturate at the limits.
- `load`  in  1: synchronous parallel load; has priority over `ce`.
- `din`  in  4*DIGITS: BCD load value; digit 0 (least significant) is in `[3:0]`.
- `q`  out  4*DIGITS: current BCD value, registered; digit 0 is in `[3:0]`.
- `tc`  out  1: combinational terminal count; `ce & ~load & (up ? all digits 9 : all digits 0)`.
- `ovf`  out  1: registered one-cycle pulse on an attempted step past a limit.
- `bad_load`  out  1: registered one-cycle pulse when `load` is taken with any `din` nibble > 9.

## Operation
- Reset: `q` = 0, `ovf` = 0, `bad_load` = 0. Reset takes effect immediately, including in the middle of a count or a load.
- Priority at each edge: `rst` > `load` > `ce` > hold.
- Load:
  - `q` takes `din` digit by digit.
  - Any nibble > 9 is stored as 9 and `bad_load` pulses for that cycle.
  - `ovf` is 0 on a load cycle.
- Increment (`ce=1, up=1`):
  - Digit 0 always steps.
  - Digit k steps only when all lower digits are 9 (ripple carry).
  - A stepping digit at 9 becomes 0; otherwise it becomes +1.
- Decrement (`ce=1, up=0`):
  - Digit k steps only when all lower digits are 0 (ripple borrow).
  - A stepping digit at 0 becomes 9; otherwise it becomes −1.
- Limits (max = all 9s = 10^DIGITS − 1, min = 0):
  - Increment at max with `sat=0`: `q` becomes 0 and `ovf` pulses.
  - Increment at max with `sat=1`: `q` holds at max and `ovf` pulses.
  - Decrement at 0 with `sat=0`: `q` becomes max and `ovf` pulses.
  - Decrement at 0 with `sat=1`: `q` holds 0 and `ovf` pulses.
- `ce=0`: `q` holds and `ovf`=0. `up` and `sat` are ignored.
- `up` and `sat` may change every cycle. Each edge uses the values sampled at that edge only.
- `q` digits always stay in 0..9. No non-BCD value is ever reachable.

## Timing
- `q` updates one edge after `ce` or `load` is sampled high; latency is 1 cycle.
- `ovf` and `bad_load` are asserted in the cycle after the causing edge, last exactly one cycle, and carry no sticky state.
- `tc` is combinational from `ce`, `load`, `up` and `q`; it is high in the same cycle as the edge that will wrap or saturate.
- Carry/borrow is combinational across all DIGITS within one cycle. There is no multi-cycle ripple and no intermediate values appear on `q`.
- `load` and `ce` both high: the load wins, no step is applied, and `tc`=0.
- Reset deassertion is synchronous to `clk` externally. The first active edge after release may count.

## Test plan (DIGITS=4)
- Reset then `ce=1, up=1` for 12 cycles -> `q` = 0x0001..0x0012 (BCD), never shows 0x000A; `ovf`=0 throughout.
- `load` with `din`=0x0999, then one up step -> `q`=0x1000; then one down step -> `q`=0x0999; `tc`=0 in all three cycles.
- `load` 0x9998 with `sat=0`, three up steps -> `q` = 0x9999, 0x0000, 0x0001; `tc`=1 only while `q`=0x9999; `ovf` high only in the cycle `q`=0x0000.
- `sat=1`, at 0x0000 `ce=1, up=0` for 3 cycles -> `q` stays 0x0000 and `ovf` pulses each cycle; with `sat=0` at 0x0000 one down step -> `q`=0x9999 and `ovf` pulses.
- `load` with `din`=0x5A3F -> `q`=0x5939 and `bad_load` pulses once; `load` and `ce` both high -> load wins with no step.
- Assert `rst` asynchronously mid-count at 0x4321 between edges -> `q`=0 immediately with `ovf`=`bad_load`=0; after release, counting resumes from 0x0001.
